// File: rtl/blink_encoder_if.sv
// Command/status bundle for the blink encoder.
// master: the command source (test sequencer or bench).
// slave:  the encoder itself.
interface blink_encoder_if;
  logic cmd_left;
  logic cmd_right;
  logic blink;
  logic busy;
  logic cmd_drop;

  modport master (
    output cmd_left,
    output cmd_right,
    input  blink,
    input  busy,
    input  cmd_drop
  );

  modport slave (
    input  cmd_left,
    input  cmd_right,
    output blink,
    output busy,
    output cmd_drop
  );
endinterface

// File: rtl/blink_encoder.sv
// Blink-count direction encoder.
// Turns a one-cycle left/right strobe into a train of blink-high pulses
// (1 pulse for left, RIGHT_PULSES for right) followed by a quiet guard
// period, so the downstream direction decoder sees each frame in its own
// counting window.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | line low, waiting for exactly one strobe
//   HIGH  | blink held high; cnt counts down the pulse width
//   GAP   | line low between two pulses of the same frame
//   GUARD | line low after the last pulse; keeps frames in separate windows
//
// One down-counter serves all three timed states; each state is left on
// the terminal count (cnt==0) and the next duration is reloaded at that
// point, so the counter never decrements through zero.
module blink_encoder #(
  parameter int unsigned CNT_W        = 29,
  parameter int unsigned HIGH_CYC     = 25_000_000,
  parameter int unsigned GAP_CYC      = 25_000_000,
  parameter int unsigned GUARD_CYC    = 268_435_456,
  parameter int unsigned RIGHT_PULSES = 2
) (
  input  logic           clk,
  input  logic           rst,
  blink_encoder_if.slave bus
);

  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("blink_encoder: CNT_W must be in 1..32");
  end
  if (HIGH_CYC < 1 || GAP_CYC < 1 || GUARD_CYC < 1) begin : g_bad_dur_min
    $error("blink_encoder: all durations must be >= 1");
  end
  if ((64'(HIGH_CYC) >> CNT_W) != 64'd0) begin : g_bad_high
    $error("blink_encoder: HIGH_CYC does not fit in CNT_W bits");
  end
  if ((64'(GAP_CYC) >> CNT_W) != 64'd0) begin : g_bad_gap
    $error("blink_encoder: GAP_CYC does not fit in CNT_W bits");
  end
  if ((64'(GUARD_CYC) >> CNT_W) != 64'd0) begin : g_bad_guard
    $error("blink_encoder: GUARD_CYC does not fit in CNT_W bits");
  end
  if (RIGHT_PULSES < 2 || RIGHT_PULSES > 7) begin : g_bad_pulses
    $error("blink_encoder: RIGHT_PULSES must be in 2..7");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    GAP   = 2'd2,
    GUARD = 2'd3
  } state_t;

  // Reload values are duration-1 because the terminal count is zero.
  localparam logic [CNT_W-1:0] HIGH_LD  = CNT_W'(HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(GUARD_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]       LEFT_N   = 3'd1;
  localparam logic [2:0]       RIGHT_N  = 3'(RIGHT_PULSES);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       pulses_left;
  logic [2:0]       pulses_nxt;
  logic             drop_nxt;
  logic             blink_q;
  logic             busy_q;
  logic             drop_q;

  logic strobe_any;
  logic strobe_both;
  logic cnt_zero;

  assign strobe_any  = bus.cmd_left | bus.cmd_right;
  assign strobe_both = bus.cmd_left & bus.cmd_right;
  assign cnt_zero    = (cnt == '0);

  // State, counter and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      pulses_left <= '0;
      blink_q     <= 1'b0;
      busy_q      <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      pulses_left <= pulses_nxt;
      blink_q     <= (state_nxt == HIGH);
      busy_q      <= (state_nxt != IDLE);
      drop_q      <= drop_nxt;
    end
  end

  // Next-state, counter reload and command-reject decision.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    pulses_nxt = pulses_left;
    drop_nxt   = 1'b0;

    unique case (state)
      IDLE: begin
        if (strobe_both) begin
          // Ambiguous direction: refuse rather than guess.
          drop_nxt = 1'b1;
        end else if (bus.cmd_left) begin
          pulses_nxt = LEFT_N;
          cnt_nxt    = HIGH_LD;
          state_nxt  = HIGH;
        end else if (bus.cmd_right) begin
          pulses_nxt = RIGHT_N;
          cnt_nxt    = HIGH_LD;
          state_nxt  = HIGH;
        end
      end

      HIGH: begin
        drop_nxt = strobe_any;
        if (!cnt_zero) begin
          cnt_nxt = cnt - CNT_ONE;
        end else if (pulses_left > 3'd1) begin
          pulses_nxt = pulses_left - 3'd1;
          cnt_nxt    = GAP_LD;
          state_nxt  = GAP;
        end else begin
          cnt_nxt   = GUARD_LD;
          state_nxt = GUARD;
        end
      end

      GAP: begin
        drop_nxt = strobe_any;
        if (!cnt_zero) begin
          cnt_nxt = cnt - CNT_ONE;
        end else begin
          cnt_nxt   = HIGH_LD;
          state_nxt = HIGH;
        end
      end

      GUARD: begin
        // Strobes on the final guard cycle are still rejected; the next
        // command is only taken once IDLE is visible.
        drop_nxt = strobe_any;
        if (!cnt_zero) begin
          cnt_nxt = cnt - CNT_ONE;
        end else begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.blink    = blink_q;
  assign bus.busy     = busy_q;
  assign bus.cmd_drop = drop_q;

endmodule
